// File: rtl/dlx_ctrl_pkg.sv
// Shared types for the multicycle DLX main control unit.
// States, opcodes, mux-select encodings and the control word.
package dlx_ctrl_pkg;

  localparam int OPW = 6;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_I_EXEC    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12
  } state_e;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_J     = 6'h02;
  localparam logic [OPW-1:0] OP_BEQZ  = 6'h04;
  localparam logic [OPW-1:0] OP_BNEZ  = 6'h05;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    SRCB_REG  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } srcb_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10
  } pcsrc_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_FUNC = 2'b10,
    ALU_IMM  = 2'b11
  } aluop_e;

  typedef struct packed {
    logic   pc_write;
    logic   pc_write_cond;
    logic   branch_ne;
    logic   i_or_d;
    logic   mem_read;
    logic   mem_write;
    logic   ir_write;
    logic   reg_dst;
    logic   reg_write;
    logic   mem_to_reg;
    logic   alu_src_a;
    srcb_e  alu_src_b;
    pcsrc_e pc_source;
    aluop_e alu_op;
    logic   illegal_op;
  } ctrl_t;

endpackage

// File: rtl/dlx_control_fsm_if.sv
// Datapath-facing bundle of the DLX control unit.
// master = control FSM, slave = datapath.
interface dlx_control_fsm_if;
  import dlx_ctrl_pkg::*;

  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           pc_write;
  logic           pc_write_cond;
  logic           branch_ne;
  logic           i_or_d;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           reg_dst;
  logic           reg_write;
  logic           mem_to_reg;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     pc_source;
  logic [1:0]     alu_op;
  logic           illegal_op;
  logic [3:0]     state_dbg;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, branch_ne,
    output i_or_d, mem_read, mem_write, ir_write,
    output reg_dst, reg_write, mem_to_reg, alu_src_a,
    output alu_src_b, pc_source, alu_op,
    output illegal_op, state_dbg
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, branch_ne,
    input  i_or_d, mem_read, mem_write, ir_write,
    input  reg_dst, reg_write, mem_to_reg, alu_src_a,
    input  alu_src_b, pc_source, alu_op,
    input  illegal_op, state_dbg
  );

endinterface

// File: rtl/dlx_ctrl_decode.sv
// Combinational state/opcode -> control word and next state.
// DECODE looks at the live opcode, later states at the latched one.
module dlx_ctrl_decode
  import dlx_ctrl_pkg::*;
(
  input  state_e         state_i,
  input  logic [OPW-1:0] opcode_i,
  input  logic [OPW-1:0] op_q_i,
  input  logic           mem_ready_i,
  output ctrl_t          ctrl_o,
  output state_e         next_o
);

  always_comb begin
    ctrl_o = '0;
    next_o = state_i;
    unique case (state_i)
      S_RESET: next_o = S_FETCH;
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
        if (mem_ready_i) next_o = S_DECODE;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM;
        unique case (opcode_i)
          OP_RTYPE:     next_o = S_R_EXEC;
          OP_LW, OP_SW: next_o = S_MEM_ADDR;
          OP_ADDI:      next_o = S_I_EXEC;
          OP_BEQZ,
          OP_BNEZ:      next_o = S_BRANCH;
          OP_J:         next_o = S_JUMP;
          default: begin
            next_o            = S_FETCH;
            ctrl_o.illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        next_o = (op_q_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
        if (mem_ready_i) next_o = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        next_o = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
        if (mem_ready_i) next_o = S_FETCH;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_FUNC;
        next_o = S_R_WB;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        next_o = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_IMM;
        next_o = S_I_WB;
      end
      S_I_WB: begin
        ctrl_o.reg_write = 1'b1;
        next_o = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
        ctrl_o.branch_ne     = op_q_i[0];
        next_o = S_FETCH;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCS_JUMP;
        next_o = S_FETCH;
      end
      default: next_o = S_RESET;
    endcase
  end

endmodule

// File: rtl/dlx_control_fsm.sv
// Multicycle DLX main control: state and opcode registers.
// One full S_RESET cycle is held after reset release.
module dlx_control_fsm
  import dlx_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  dlx_control_fsm_if.master  bus
);

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q;
  logic           hold_q;
  ctrl_t          ctrl;

  dlx_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .op_q_i      (op_q),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl),
    .next_o      (state_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      op_q    <= '0;
      hold_q  <= 1'b1;
    end else begin
      hold_q  <= 1'b0;
      state_q <= hold_q ? S_RESET : state_d;
      if (state_q == S_DECODE) op_q <= bus.opcode;
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.branch_ne     = ctrl.branch_ne;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_dlx_control_fsm.sv
// Bench for dlx_control_fsm: per-instruction expected cycle
// sequences are queued and compared cycle by cycle.
module tb_dlx_control_fsm;
  import dlx_ctrl_pkg::*;

  typedef struct packed {
    logic       pw, pwc, bne, iod, mrd, mwr, irw;
    logic       rdst, rwr, m2r, asa;
    logic [1:0] asb, pcs, aop;
    logic       ill;
  } exp_t;

  typedef struct {
    logic       mr;
    state_e     st;
    exp_t       e;
    logic [5:0] op;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  ent_t q[$];
  exp_t got;

  dlx_control_fsm_if bus ();

  dlx_control_fsm u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  assign got = {bus.pc_write, bus.pc_write_cond, bus.branch_ne,
                bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.reg_dst, bus.reg_write,
                bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
                bus.pc_source, bus.alu_op, bus.illegal_op};

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  // 0 R, 1 LW, 2 SW, 3 ADDI, 4 branch, 5 J, 6 illegal
  function automatic int kind(input logic [5:0] op);
    case (op)
      6'h00:        return 0;
      6'h23:        return 1;
      6'h2B:        return 2;
      6'h08:        return 3;
      6'h04, 6'h05: return 4;
      6'h02:        return 5;
      default:      return 6;
    endcase
  endfunction

  task automatic push(input logic mr, input state_e st,
                      input exp_t e, input logic [5:0] op);
    ent_t x;
    x.mr = mr; x.st = st; x.e = e; x.op = op;
    q.push_back(x);
  endtask

  task automatic build(input logic [5:0] op,
                       input int wf, input int wm);
    exp_t   e;
    int     k;
    state_e ms;
    k = kind(op);
    e = '0; e.mrd = 1'b1; e.asb = 2'b01;
    for (int i = 0; i < wf; i++) push(1'b0, S_FETCH, e, op);
    e.irw = 1'b1; e.pw = 1'b1;
    push(1'b1, S_FETCH, e, op);
    e = '0; e.asb = 2'b10; e.ill = (k == 6);
    push(1'($urandom), S_DECODE, e, op);
    e = '0;
    case (k)
      0: begin
        e.asa = 1'b1; e.aop = 2'b10;
        push(1'($urandom), S_R_EXEC, e, op);
        e = '0; e.rwr = 1'b1; e.rdst = 1'b1;
        push(1'($urandom), S_R_WB, e, op);
      end
      1, 2: begin
        e.asa = 1'b1; e.asb = 2'b10;
        push(1'($urandom), S_MEM_ADDR, e, op);
        e = '0; e.iod = 1'b1;
        if (k == 1) begin e.mrd = 1'b1; ms = S_MEM_READ; end
        else begin e.mwr = 1'b1; ms = S_MEM_WRITE; end
        for (int i = 0; i < wm; i++) push(1'b0, ms, e, op);
        push(1'b1, ms, e, op);
        if (k == 1) begin
          e = '0; e.rwr = 1'b1; e.m2r = 1'b1;
          push(1'($urandom), S_MEM_WB, e, op);
        end
      end
      3: begin
        e.asa = 1'b1; e.asb = 2'b10; e.aop = 2'b11;
        push(1'($urandom), S_I_EXEC, e, op);
        e = '0; e.rwr = 1'b1;
        push(1'($urandom), S_I_WB, e, op);
      end
      4: begin
        e.asa = 1'b1; e.aop = 2'b01; e.pwc = 1'b1;
        e.pcs = 2'b01; e.bne = op[0];
        push(1'($urandom), S_BRANCH, e, op);
      end
      5: begin
        e.pw = 1'b1; e.pcs = 2'b10;
        push(1'($urandom), S_JUMP, e, op);
      end
      default: ;
    endcase
  endtask

  // Only DECODE sees the real opcode; elsewhere it is garbage.
  task automatic run(input bit stop_mw);
    ent_t x;
    while (q.size() > 0) begin
      x = q.pop_front();
      @(negedge clk);
      bus.mem_ready = x.mr;
      bus.opcode = (x.st == S_DECODE) ? x.op : 6'($urandom);
      bus.zero = 1'($urandom);
      #1;
      check($sformatf("state op%0h", x.op),
            32'(bus.state_dbg), 32'(x.st));
      check($sformatf("ctrl %s op%0h", x.st.name(), x.op),
            32'(got), 32'(x.e));
      if (stop_mw && x.st == S_MEM_WRITE) break;
    end
  endtask

  logic [5:0] ops [7] = '{6'h00, 6'h23, 6'h2B, 6'h08,
                          6'h04, 6'h05, 6'h02};
  logic [5:0] op;

  initial begin
    reset = 1'b1;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst state", 32'(bus.state_dbg), 32'(S_RESET));
    check("rst ctrl", 32'(got), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    push(1'($urandom), S_RESET, '0, 6'h00);
    build(6'h00, 0, 0);
    build(6'h23, 0, 3);
    build(6'h05, 0, 0);
    build(6'h04, 0, 0);
    build(6'h02, 0, 0);
    build(6'h3F, 0, 0);
    build(6'h00, 2, 0);
    build(6'h2B, 1, 2);
    build(6'h08, 0, 0);
    run(1'b0);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 6)];
      build(op, $urandom_range(0, 2), $urandom_range(0, 3));
      run(1'b0);
    end

    build(6'h2B, 0, 3);
    run(1'b1);
    check("mw before rst", 32'(bus.mem_write), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mw async rst", 32'(bus.mem_write), 32'h0);
    check("st async rst", 32'(bus.state_dbg), 32'(S_RESET));
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    push(1'($urandom), S_RESET, '0, 6'h00);
    build(6'h00, 0, 0);
    run(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
